// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: core writeback constants and request type, shared with the register file.
package wb_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_WB_SRC = 3;
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational N-way round-robin pick starting after i_last; reusable for other shared ports.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         i_req,
  input  logic                 i_en,
  input  logic [$clog2(N)-1:0] i_last,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_any
);
  localparam int IW = $clog2(N);
  logic w_hit;
  // Walk the ring from last+1; the first requester found wins.
  always_comb begin
    logic [IW-1:0] c;
    o_idx = '0;
    w_hit = 1'b0;
    c = i_last;
    for (int k = 0; k < N; k++) begin
      c = (c == IW'(N - 1)) ? '0 : c + IW'(1);
      if (!w_hit && i_req[c]) begin
        o_idx = c;
        w_hit = 1'b1;
      end
    end
  end
  assign o_any   = w_hit & i_en;
  assign o_grant = o_any ? N'(1) << o_idx : '0;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin sharing of the register file write port among writeback sources,
// with a one-cycle staged write that also serves as a bypass source.
module wb_arbiter import wb_arbiter_pkg::*; #(
  parameter int NUM_SRC = NUM_WB_SRC,
  parameter int WIDTH   = XLEN,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_SRC-1:0]          req_valid,
  input  logic [NUM_SRC*ADDR_W-1:0]   req_rd,
  input  logic [NUM_SRC*WIDTH-1:0]    req_data,
  output logic [NUM_SRC-1:0]          req_ready,
  input  logic                        wb_hold,
  output logic                        reg_write,
  output logic [ADDR_W-1:0]           waddr,
  output logic [WIDTH-1:0]            wdata,
  output logic [$clog2(NUM_SRC)-1:0]  grant_idx
);
  localparam int IW = $clog2(NUM_SRC);
  logic [NUM_SRC-1:0] w_grant;
  logic [IW-1:0]      w_idx;
  logic               w_fire;
  logic               w_en;
  logic [ADDR_W-1:0]  w_rd;
  logic [WIDTH-1:0]   w_data;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [WIDTH-1:0]   r_data;
  logic [IW-1:0]      r_idx;
  logic [IW-1:0]      r_last;
  // Reset gates grants combinationally so nothing transfers while reset_n is low.
  assign w_en = ~wb_hold & reset_n;
  rr_arbiter #(.N(NUM_SRC)) u_rr (
    .i_req   (req_valid),
    .i_en    (w_en),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_fire)
  );
  always_comb begin
    w_rd   = '0;
    w_data = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (w_grant[i]) begin
        w_rd   = req_rd[i*ADDR_W +: ADDR_W];
        w_data = req_data[i*WIDTH +: WIDTH];
      end
  end
  // Writes to x0 are consumed and advance the pointer but never strobe the register file.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_idx  <= '0;
      r_last <= IW'(NUM_SRC - 1);
    end else begin
      r_we <= w_fire && (w_rd != '0);
      if (w_fire) begin
        r_addr <= w_rd;
        r_data <= w_data;
        r_idx  <= w_idx;
        r_last <= w_idx;
      end
    end
  assign req_ready = w_grant;
  assign reg_write = r_we;
  assign waddr     = r_addr;
  assign wdata     = r_data;
  assign grant_idx = r_idx;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vector table plus hand sequences and a random round-robin scoreboard.
module tb_wb_arbiter;
  localparam int N = 3, W = 32, A = 5;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req_valid, req_ready;
  logic [N*A-1:0] req_rd;
  logic [N*W-1:0] req_data;
  logic wb_hold, reg_write;
  logic [A-1:0] waddr;
  logic [W-1:0] wdata;
  logic [1:0] grant_idx;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.NUM_SRC(N), .WIDTH(W), .ADDR_W(A)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_rd(req_rd),
    .req_data(req_data), .req_ready(req_ready), .wb_hold(wb_hold),
    .reg_write(reg_write), .waddr(waddr), .wdata(wdata), .grant_idx(grant_idx)
  );

  typedef struct {
    logic [2:0] valid;
    logic       hold;
    logic       x0;
    logic [2:0] ready;
  } vec_t;
  vec_t tbl[19];

  logic         p_we, p_any;
  logic [A-1:0] p_a;
  logic [W-1:0] p_d;
  logic [1:0]   p_i;
  logic [W-1:0] ref_rf[32], dut_rf[32];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic chk_stage(input string tag);
    chk({tag, "_we"}, reg_write, p_we);
    if (p_we) begin
      chk({tag, "_waddr"}, waddr, p_a);
      chk({tag, "_wdata"}, wdata, p_d);
    end
    if (p_any) chk({tag, "_gidx"}, grant_idx, p_i);
  endtask

  function automatic logic [A-1:0] rd_of(input int r, input int s);
    return A'((r * 3 + s) % 31 + 1);
  endfunction

  function automatic logic [W-1:0] data_of(input int r, input int s);
    return 32'hC0DE_0000 | W'(r << 4) | W'(s);
  endfunction

  function automatic int oh2i(input logic [2:0] v);
    int r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic set_src(input int s, input logic [A-1:0] rd, input logic [W-1:0] d);
    req_rd[s*A +: A]   = rd;
    req_data[s*W +: W] = d;
  endtask

  initial begin
    logic [A-1:0] srd[N];
    logic [W-1:0] sdat[N];
    logic [N-1:0] sv;
    int waitc[N];
    int mlast, win;
    tbl[0]  = '{3'b111, 1'b0, 1'b0, 3'b001};
    tbl[1]  = '{3'b111, 1'b0, 1'b0, 3'b010};
    tbl[2]  = '{3'b111, 1'b0, 1'b0, 3'b100};
    tbl[3]  = '{3'b111, 1'b0, 1'b0, 3'b001};
    tbl[4]  = '{3'b111, 1'b0, 1'b0, 3'b010};
    tbl[5]  = '{3'b111, 1'b0, 1'b0, 3'b100};
    tbl[6]  = '{3'b010, 1'b0, 1'b0, 3'b010};
    tbl[7]  = '{3'b000, 1'b0, 1'b0, 3'b000};
    tbl[8]  = '{3'b101, 1'b0, 1'b0, 3'b100};
    tbl[9]  = '{3'b101, 1'b1, 1'b0, 3'b000};
    tbl[10] = '{3'b100, 1'b1, 1'b0, 3'b000};
    tbl[11] = '{3'b100, 1'b1, 1'b0, 3'b000};
    tbl[12] = '{3'b100, 1'b0, 1'b0, 3'b100};
    tbl[13] = '{3'b011, 1'b0, 1'b0, 3'b001};
    tbl[14] = '{3'b001, 1'b0, 1'b1, 3'b001};
    tbl[15] = '{3'b111, 1'b0, 1'b0, 3'b010};
    tbl[16] = '{3'b001, 1'b0, 1'b0, 3'b001};
    tbl[17] = '{3'b110, 1'b0, 1'b0, 3'b010};
    tbl[18] = '{3'b000, 1'b0, 1'b0, 3'b000};

    req_valid = 3'b111;
    wb_hold   = 1'b0;
    for (int s = 0; s < N; s++) set_src(s, rd_of(40, s), data_of(40, s));
    #2;
    chk("rst_ready", req_ready, 3'b000);
    chk("rst_we", reg_write, 1'b0);
    chk("rst_waddr", waddr, '0);
    chk("rst_wdata", wdata, '0);
    chk("rst_gidx", grant_idx, '0);
    @(negedge clk);
    reset_n   = 1'b1;
    req_valid = '0;

    for (int r = 0; r < 19; r++) begin
      @(negedge clk);
      if (r > 0) chk_stage("tbl");
      req_valid = tbl[r].valid;
      wb_hold   = tbl[r].hold;
      for (int s = 0; s < N; s++) set_src(s, tbl[r].x0 ? '0 : rd_of(r, s), data_of(r, s));
      #1;
      chk($sformatf("tbl%0d_ready", r), req_ready, tbl[r].ready);
      p_any = |tbl[r].ready;
      p_we  = p_any && !tbl[r].x0;
      p_i   = 2'(oh2i(tbl[r].ready));
      p_a   = rd_of(r, oh2i(tbl[r].ready));
      p_d   = data_of(r, oh2i(tbl[r].ready));
    end
    @(negedge clk);
    chk_stage("tbl");

    req_valid = 3'b010;
    set_src(1, 5'd5, 32'hDEAD_BEEF);
    #1;
    chk("single_ready", req_ready, 3'b010);
    @(negedge clk);
    req_valid = '0;
    chk("single_we", reg_write, 1'b1);
    chk("single_waddr", waddr, 5'd5);
    chk("single_wdata", wdata, 32'hDEAD_BEEF);
    chk("single_gidx", grant_idx, 2'd1);
    @(negedge clk);
    chk("single_we_off", reg_write, 1'b0);

    req_valid = 3'b001;
    set_src(0, 5'd7, 32'h5A5A_0001);
    @(posedge clk);
    #2;
    chk("mid_we", reg_write, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_we", reg_write, 1'b0);
    chk("mid_rst_waddr", waddr, '0);
    chk("mid_rst_wdata", wdata, '0);
    chk("mid_rst_ready", req_ready, 3'b000);
    @(negedge clk);
    reset_n   = 1'b1;
    req_valid = 3'b111;
    for (int s = 0; s < N; s++) set_src(s, rd_of(50, s), data_of(50, s));
    #1;
    chk("post_rst_ready", req_ready, 3'b001);
    @(negedge clk);
    chk("post_rst_we", reg_write, 1'b1);
    chk("post_rst_waddr", waddr, rd_of(50, 0));
    req_valid = '0;

    mlast = 0;
    sv    = '0;
    p_we  = 1'b0;
    p_any = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ref_rf[i] = '0;
      dut_rf[i] = '0;
    end
    for (int s = 0; s < N; s++) waitc[s] = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      chk_stage("rnd");
      if (p_we) ref_rf[p_a] = p_d;
      if (reg_write) dut_rf[waddr] = wdata;
      for (int s = 0; s < N; s++)
        if (!sv[s]) begin
          sv[s]   = ($urandom_range(0, 2) != 0);
          srd[s]  = A'($urandom_range(0, 31));
          sdat[s] = $urandom;
          waitc[s] = 0;
        end
      wb_hold   = ($urandom_range(0, 9) == 0);
      req_valid = sv;
      for (int s = 0; s < N; s++) set_src(s, srd[s], sdat[s]);
      #1;
      win = -1;
      if (!wb_hold)
        for (int k = 1; k <= N; k++)
          if (win < 0 && sv[(mlast + k) % N]) win = (mlast + k) % N;
      chk("rnd_ready", req_ready, win >= 0 ? 3'(1 << win) : 3'b000);
      for (int s = 0; s < N; s++) if (sv[s] && !wb_hold) waitc[s]++;
      p_any = (win >= 0);
      p_we  = 1'b0;
      if (win >= 0) begin
        total++;
        if (waitc[win] > N) begin
          bad++;
          $display("FAIL starve src%0d wait=%0d limit=%0d", win, waitc[win], N);
        end
        p_we    = (srd[win] != '0);
        p_a     = srd[win];
        p_d     = sdat[win];
        p_i     = 2'(win);
        sv[win] = 1'b0;
        mlast   = win;
      end
    end
    @(negedge clk);
    chk_stage("rnd");
    if (p_we) ref_rf[p_a] = p_d;
    if (reg_write) dut_rf[waddr] = wdata;
    for (int i = 1; i < 32; i++) chk($sformatf("rf_x%0d", i), dut_rf[i], ref_rf[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
